// File: rtl/bellek_erisim_birimi.sv
// Load/store stage behind the ALU: valid/ready data-memory port, load extension, store lane masks.
// Optional misalignment trapping is enabled by defining BELLEK_HIZALAMA_DENETIM_EN.
module bellek_erisim_birimi #(
  parameter int unsigned ZAMAN_ASIMI = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        bellek_aktif_i,
  input  logic [5:0]  islem_kodu_i,
  input  logic [31:0] adres_i,
  input  logic [31:0] veri_i,
  input  logic [4:0]  hedef_yazmac_i,
  output logic        vy_istek_o,
  output logic        vy_yaz_o,
  output logic [31:0] vy_adres_o,
  output logic [31:0] vy_yaz_veri_o,
  output logic [3:0]  vy_yaz_maske_o,
  input  logic        vy_hazir_i,
  input  logic [31:0] vy_oku_veri_i,
  output logic [31:0] sonuc_o,
  output logic [4:0]  hedef_yazmac_o,
  output logic        yazmac_yaz_o,
  output logic        bellek_hazir_o,
  output logic        durdur_o,
  output logic        hizasiz_o,
  output logic        zaman_asimi_o
);
  localparam int unsigned SAYAC_W = 8;

  // Opcode encodings shared with operations.vh
  localparam logic [5:0] MEM_LB  = 6'h20;
  localparam logic [5:0] MEM_LH  = 6'h21;
  localparam logic [5:0] MEM_LW  = 6'h22;
  localparam logic [5:0] MEM_LBU = 6'h23;
  localparam logic [5:0] MEM_LHU = 6'h24;
  localparam logic [5:0] MEM_SB  = 6'h25;
  localparam logic [5:0] MEM_SH  = 6'h26;
  localparam logic [5:0] MEM_SW  = 6'h27;

  typedef enum logic [1:0] {BOSTA = 2'd0, ISTEK = 2'd1, TAMAM = 2'd2} durum_t;

  function automatic logic mem_islem(input logic [5:0] op);
    mem_islem = (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) || (op == MEM_LBU) ||
                (op == MEM_LHU) || (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  function automatic logic yazma_islem(input logic [5:0] op);
    yazma_islem = (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  // Select the addressed byte/half of the returned word and extend it
  function automatic logic [31:0] yukle_genislet(input logic [5:0] op, input logic [1:0] a,
                                                 input logic [31:0] v);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = v[7:0];
      2'd1:    b = v[15:8];
      2'd2:    b = v[23:16];
      default: b = v[31:24];
    endcase
    h = a[1] ? v[31:16] : v[15:0];
    case (op)
      MEM_LB:  yukle_genislet = {{24{b[7]}}, b};
      MEM_LBU: yukle_genislet = {24'd0, b};
      MEM_LH:  yukle_genislet = {{16{h[15]}}, h};
      MEM_LHU: yukle_genislet = {16'd0, h};
      default: yukle_genislet = v;
    endcase
  endfunction

  durum_t              durum_q, durum_d;
  logic [SAYAC_W-1:0]  sayac_q, sayac_d;
  logic [5:0]          islem_q, islem_d;
  logic [1:0]          serit_q, serit_d;
  logic [4:0]          hedef_q, hedef_d;
  logic                vy_istek_q, vy_istek_d;
  logic                vy_yaz_q, vy_yaz_d;
  logic [31:0]         vy_adres_q, vy_adres_d;
  logic [31:0]         vy_yaz_veri_q, vy_yaz_veri_d;
  logic [3:0]          vy_yaz_maske_q, vy_yaz_maske_d;
  logic [31:0]         sonuc_q, sonuc_d;
  logic [4:0]          hedef_cikis_q, hedef_cikis_d;
  logic                yazmac_yaz_q, yazmac_yaz_d;
  logic                bellek_hazir_q, bellek_hazir_d;
  logic                hizasiz_q, hizasiz_d;
  logic                zaman_asimi_q, zaman_asimi_d;

  logic                kabul;
  logic                hizasiz_giris;
  logic [3:0]          yaz_maske;
  logic [31:0]         yaz_veri;

  assign kabul = (durum_q == BOSTA) && bellek_aktif_i && mem_islem(islem_kodu_i);

  // Alignment trap on the incoming access
  always_comb begin
    hizasiz_giris = 1'b0;
`ifdef BELLEK_HIZALAMA_DENETIM_EN
    if ((islem_kodu_i == MEM_LH) || (islem_kodu_i == MEM_LHU) || (islem_kodu_i == MEM_SH))
      hizasiz_giris = adres_i[0];
    else if ((islem_kodu_i == MEM_LW) || (islem_kodu_i == MEM_SW))
      hizasiz_giris = |adres_i[1:0];
`endif
  end

  // Store lane mask and lane-replicated write data
  always_comb begin
    yaz_maske = 4'b0000;
    yaz_veri  = veri_i;
    case (islem_kodu_i)
      MEM_SB: begin
        yaz_maske = 4'b0001 << adres_i[1:0];
        yaz_veri  = {4{veri_i[7:0]}};
      end
      MEM_SH: begin
        yaz_maske = 4'b0011 << {adres_i[1], 1'b0};
        yaz_veri  = {2{veri_i[15:0]}};
      end
      MEM_SW:  yaz_maske = 4'b1111;
      default: ;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    durum_d        = durum_q;
    sayac_d        = sayac_q;
    islem_d        = islem_q;
    serit_d        = serit_q;
    hedef_d        = hedef_q;
    vy_istek_d     = vy_istek_q;
    vy_yaz_d       = vy_yaz_q;
    vy_adres_d     = vy_adres_q;
    vy_yaz_veri_d  = vy_yaz_veri_q;
    vy_yaz_maske_d = vy_yaz_maske_q;
    sonuc_d        = sonuc_q;
    hedef_cikis_d  = hedef_cikis_q;
    yazmac_yaz_d   = 1'b0;
    bellek_hazir_d = 1'b0;
    hizasiz_d      = 1'b0;
    zaman_asimi_d  = 1'b0;
    case (durum_q)
      BOSTA: begin
        if (kabul) begin
          islem_d = islem_kodu_i;
          serit_d = adres_i[1:0];
          hedef_d = hedef_yazmac_i;
          sayac_d = '0;
          if (hizasiz_giris) begin
            durum_d        = TAMAM;
            bellek_hazir_d = 1'b1;
            hizasiz_d      = 1'b1;
            sonuc_d        = 32'd0;
            hedef_cikis_d  = hedef_yazmac_i;
          end else begin
            durum_d        = ISTEK;
            vy_istek_d     = 1'b1;
            vy_yaz_d       = yazma_islem(islem_kodu_i);
            vy_adres_d     = {adres_i[31:2], 2'b00};
            vy_yaz_veri_d  = yaz_veri;
            vy_yaz_maske_d = yaz_maske;
          end
        end
      end
      ISTEK: begin
        if (vy_hazir_i || (sayac_q == SAYAC_W'(ZAMAN_ASIMI - 1))) begin
          durum_d        = TAMAM;
          vy_istek_d     = 1'b0;
          vy_yaz_d       = 1'b0;
          vy_adres_d     = 32'd0;
          vy_yaz_veri_d  = 32'd0;
          vy_yaz_maske_d = 4'b0000;
          bellek_hazir_d = 1'b1;
          hedef_cikis_d  = hedef_q;
          sonuc_d        = 32'd0;
          // An acknowledge on the last allowed cycle still counts as success
          if (vy_hazir_i) begin
            if (!yazma_islem(islem_q)) begin
              sonuc_d      = yukle_genislet(islem_q, serit_q, vy_oku_veri_i);
              yazmac_yaz_d = (hedef_q != 5'd0);
            end
          end else begin
            zaman_asimi_d = 1'b1;
          end
        end else begin
          sayac_d = sayac_q + SAYAC_W'(1);
        end
      end
      TAMAM:   durum_d = BOSTA;
      default: durum_d = BOSTA;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum_q        <= BOSTA;
      sayac_q        <= '0;
      islem_q        <= 6'd0;
      serit_q        <= 2'd0;
      hedef_q        <= 5'd0;
      vy_istek_q     <= 1'b0;
      vy_yaz_q       <= 1'b0;
      vy_adres_q     <= 32'd0;
      vy_yaz_veri_q  <= 32'd0;
      vy_yaz_maske_q <= 4'b0000;
      sonuc_q        <= 32'd0;
      hedef_cikis_q  <= 5'd0;
      yazmac_yaz_q   <= 1'b0;
      bellek_hazir_q <= 1'b0;
      hizasiz_q      <= 1'b0;
      zaman_asimi_q  <= 1'b0;
    end else begin
      durum_q        <= durum_d;
      sayac_q        <= sayac_d;
      islem_q        <= islem_d;
      serit_q        <= serit_d;
      hedef_q        <= hedef_d;
      vy_istek_q     <= vy_istek_d;
      vy_yaz_q       <= vy_yaz_d;
      vy_adres_q     <= vy_adres_d;
      vy_yaz_veri_q  <= vy_yaz_veri_d;
      vy_yaz_maske_q <= vy_yaz_maske_d;
      sonuc_q        <= sonuc_d;
      hedef_cikis_q  <= hedef_cikis_d;
      yazmac_yaz_q   <= yazmac_yaz_d;
      bellek_hazir_q <= bellek_hazir_d;
      hizasiz_q      <= hizasiz_d;
      zaman_asimi_q  <= zaman_asimi_d;
    end
  end

  assign vy_istek_o     = vy_istek_q;
  assign vy_yaz_o       = vy_yaz_q;
  assign vy_adres_o     = vy_adres_q;
  assign vy_yaz_veri_o  = vy_yaz_veri_q;
  assign vy_yaz_maske_o = vy_yaz_maske_q;
  assign sonuc_o        = sonuc_q;
  assign hedef_yazmac_o = hedef_cikis_q;
  assign yazmac_yaz_o   = yazmac_yaz_q;
  assign bellek_hazir_o = bellek_hazir_q;
  assign hizasiz_o      = hizasiz_q;
  assign zaman_asimi_o  = zaman_asimi_q;
  // Stall is combinational so the accepting cycle already holds the pipeline
  assign durdur_o       = ~rst_i & (kabul | (durum_q == ISTEK));
endmodule

// File: doc/bellek_erisim_birimi.md
# bellek_erisim_birimi

Load/store stage placed directly downstream of the ALU (AMB). It takes the effective address computed by the ALU for `MEM_*` opcodes and performs the data-memory transaction over a valid/ready handshake. For loads it aligns and sign- or zero-extends the returned data; for stores it generates byte-lane masks. It stalls the pipeline while a transaction is in flight.

## Interface
- `ZAMAN_ASIMI`, default 255: maximum number of cycles to wait for `vy_hazir_i` before the transaction is aborted (range 1..255).
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `bellek_aktif_i` in 1: the current instruction is a memory operation and its operands are valid.
- `islem_kodu_i` in 6: opcode, one of `MEM_LB/LH/LW/LBU/LHU/SB/SH/SW` from operations.vh.
- `adres_i` in 32: effective address (ALU `sonuc_o`).
- `veri_i` in 32: store data (rs2 value).
- `hedef_yazmac_i` in 5: load destination register.
- `vy_istek_o` out 1: memory request valid.
- `vy_yaz_o` out 1: 1 = write, 0 = read.
- `vy_adres_o` out 32: word address, `{adres[31:2],2'b00}`.
- `vy_yaz_veri_o` out 32: lane-replicated store data.
- `vy_yaz_maske_o` out 4: byte-enable mask.
- `vy_hazir_i` in 1: memory accept/complete.
- `vy_oku_veri_i` in 32: read data, valid when `vy_hazir_i` is high.
- `sonuc_o` out 32: extended load data.
- `hedef_yazmac_o` out 5: latched destination register.
- `yazmac_yaz_o` out 1: register-file write enable, valid while `bellek_hazir_o` is high.
- `bellek_hazir_o` out 1: one-cycle completion pulse.
- `durdur_o` out 1: pipeline stall request.
- `hizasiz_o` out 1: misalignment exception pulse.
- `zaman_asimi_o` out 1: timeout exception pulse.

## Operation
- FSM states: BOSTA, ISTEK, TAMAM.
- **BOSTA:** when `bellek_aktif_i` is high with a `MEM_*` opcode, latch the opcode, address, data and destination register. Go to ISTEK, or to TAMAM if the access is misaligned (see Configuration). `bellek_aktif_i` with any non-`MEM_*` opcode is ignored.
- **ISTEK:** `vy_istek_o`=1 and all `vy_*` outputs are held stable. `vy_hazir_i`=1 completes the transfer: capture read data and go to TAMAM. A wait counter increments each cycle without acknowledge. On reaching `ZAMAN_ASIMI`, drop the request and go to TAMAM with the timeout flag set.
- **TAMAM:** `bellek_hazir_o`=1 for exactly one cycle, then return to BOSTA.
- `yazmac_yaz_o`=1 in TAMAM only for a successful load with `hedef_yazmac` != 0.
- Load extension uses lane `a=adres[1:0]`:
  - LB/LBU: byte a, sign- or zero-extended.
  - LH/LHU: half `adres[1]`, sign- or zero-extended.
  - LW: full word.
- Store mask and data:
  - SB: mask `4'b0001<<a`, data `{4{veri[7:0]}}`.
  - SH: mask `4'b0011<<{adres[1],1'b0}`, data `{2{veri[15:0]}}`.
  - SW: mask 4'b1111, data `veri`.
  - `vy_yaz_maske_o`=0 for loads.
- `sonuc_o` and `hedef_yazmac_o` hold their values until the next TAMAM. For stores, an error, or a timeout, `sonuc_o` is 0.
- `durdur_o` = (BOSTA & accept) | ISTEK.
- `bellek_aktif_i` is ignored outside BOSTA.

## Timing
- Reset values: state BOSTA, counter 0, every output 0. Reset is asynchronous, so `vy_istek_o` drops immediately even mid-transaction, and any latched transaction is discarded.
- Accept at cycle N. `vy_istek_o` is high from N+1.
- Acknowledge at cycle M (the first cycle with `vy_istek_o & vy_hazir_i`). `bellek_hazir_o`, `sonuc_o` and `yazmac_yaz_o` are valid at M+1.
- Zero-wait memory (acknowledge at N+1) gives completion at N+2. Throughput is one access per 3 cycles.
- `vy_hazir_i` sampled outside ISTEK has no effect.
- Timeout: with no acknowledge, `vy_istek_o` is high for exactly `ZAMAN_ASIMI` cycles. `zaman_asimi_o` and `bellek_hazir_o` pulse together in the following cycle.
- Acknowledge in the same cycle the counter hits the limit counts as success (acknowledge wins).
- Misaligned access: completion with `hizasiz_o` at N+1, and no memory request is issued.

## Configuration
- `BELLEK_HIZALAMA_DENETIM_EN` defined:
  - LH/LHU/SH with `adres[0]`=1, and LW/SW with `adres[1:0]`!=0, are misaligned.
  - They bypass ISTEK and pulse `hizasiz_o` in TAMAM, with `yazmac_yaz_o`=0.
- Undefined:
  - `hizasiz_o` is tied 0.
  - Halfword lane select uses `adres[1]` only, and word accesses ignore `adres[1:0]`.
  - The access proceeds normally.

## Test plan
- LW at 0x100 with zero-wait memory returning 0xDEADBEEF -> at N+2: `sonuc_o`=0xDEADBEEF, `yazmac_yaz_o`=1, `hedef_yazmac_o` as latched.
- LB at 0x103 with 3 wait cycles, memory returning 0x80FF_0000 -> `sonuc_o`=0xFFFFFF80. LBU of the same -> 0x00000080. Completion occurs 1 cycle after the acknowledge.
- SH at 0x202 with `veri_i`=0x1234ABCD -> `vy_yaz_maske_o`=4'b1100, `vy_yaz_veri_o`=0xABCDABCD, `vy_adres_o`=0x200, `yazmac_yaz_o`=0.
- `ZAMAN_ASIMI`=4, no acknowledge -> `vy_istek_o` high for 4 cycles, then `zaman_asimi_o`=`bellek_hazir_o`=1, `sonuc_o`=0, `durdur_o` released.
- With the macro defined, LW at 0x102 -> `hizasiz_o`=1 at N+1 and `vy_istek_o` never asserts. With the macro undefined -> read issued at 0x100.
- `rst_i` asserted asynchronously while in ISTEK -> `vy_istek_o` and `durdur_o` drop before the next clock edge, and no `bellek_hazir_o` pulse follows.
